// File: rtl/biquad_log_writer.sv
// Wishbone write master that records the biquad output stream into the logging blockram.
// Define LOG_WRAP_EN for circular capture (ends only on stop); default is one-shot capture of DEPTH words.
module biquad_log_writer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic [7:0]        decim_i,
    input  logic              arm_i,
    input  logic              stop_i,
    output logic              log_wb_cyc_o,
    output logic              log_wb_stb_o,
    output logic              log_wb_we_o,
    output logic [ADDR_W-1:0] log_wb_adr_o,
    output logic [DATA_W-1:0] log_wb_dat_o,
    input  logic              log_wb_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic [ADDR_W:0]   wr_ptr_o
);

    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              pend_q, pend_d;
    logic              sel_s;
    logic              full_s;
    logic [PTR_W-1:0]  ptr_inc_s;

    // A valid sample is selected when the decimation counter completes its period.
    always_comb begin
        sel_s = sample_valid_i && ((decim_i <= 8'd1) || (cnt_q == (decim_i - 8'd1)));
    end

`ifdef LOG_WRAP_EN
    // Circular mode: pointer saturates at DEPTH and never ends the capture by itself.
    always_comb begin
        full_s = 1'b0;
        if (ptr_q == DEPTH_P) begin
            ptr_inc_s = ptr_q;
        end else begin
            ptr_inc_s = ptr_q + PTR_W'(1);
        end
    end
`else
    // One-shot mode: the write that brings the pointer to DEPTH closes the capture.
    always_comb begin
        ptr_inc_s = ptr_q + PTR_W'(1);
        full_s    = (ptr_inc_s == DEPTH_P);
    end
`endif

    // Next-state logic for the capture controller and bus signals.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        pend_d  = pend_q;
        if ((state_q != S_IDLE) && sample_valid_i) begin
            cnt_d = sel_s ? 8'd0 : (cnt_q + 8'd1);
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            S_IDLE: begin
                if (arm_i) begin
                    ptr_d   = '0;
                    addr_d  = '0;
                    cnt_d   = 8'd0;
                    done_d  = 1'b0;
                    ovr_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (stop_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (sel_s) begin
                    dat_d   = sample_i;
                    adr_d   = addr_q;
                    cyc_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WRITE: begin
                if (sel_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (stop_i) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                // The bus cycle is held until ack; a stop never abandons it.
                if (log_wb_ack_i) begin
                    cyc_d  = 1'b0;
                    ptr_d  = ptr_inc_s;
                    addr_d = (addr_q == LAST_ADDR) ? '0 : (addr_q + ADDR_W'(1));
                    if (full_s || pend_q || stop_i) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
        end
    end

    // cyc, stb and we come from one register so we can never be high outside a cycle.
    assign log_wb_cyc_o = cyc_q;
    assign log_wb_stb_o = cyc_q;
    assign log_wb_we_o  = cyc_q;
    assign log_wb_adr_o = adr_q;
    assign log_wb_dat_o = dat_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overrun_o    = ovr_q;
    assign wr_ptr_o     = ptr_q;

endmodule

// File: tb/tb_biquad_log_writer.sv
// Self-checking bench for biquad_log_writer: timestamp-based reference model, Wishbone slave with RAM,
// and directed scenarios. Build with LOG_WRAP_EN defined to exercise circular capture.
module tb_biquad_log_writer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2048;
`ifdef LOG_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] sample = '0;
    logic              valid = 1'b0;
    logic [7:0]        decim = 8'd1;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic              cyc, stb, we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic              ack = 1'b0;
    logic              busy, done, ovr;
    logic [ADDR_W:0]   wr_ptr;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    int                ack_cnt = 0;
    int                checks = 0;
    int                errors = 0;

    biquad_log_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sample_i(sample), .sample_valid_i(valid),
        .decim_i(decim), .arm_i(arm), .stop_i(stop),
        .log_wb_cyc_o(cyc), .log_wb_stb_o(stb), .log_wb_we_o(we), .log_wb_adr_o(adr),
        .log_wb_dat_o(dat), .log_wb_ack_i(ack), .busy_o(busy), .done_o(done),
        .overrun_o(ovr), .wr_ptr_o(wr_ptr)
    );

    always #5 clk = ~clk;

    // Write-only slave with a registered single ack per cycle.
    always @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0;
        end else begin
            ack <= cyc && stb && !ack;
            if (cyc && stb && we && !ack) mem[adr] <= dat;
            if (cyc && stb && ack) ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a write accepted at edge k holds the bus until the ack sampled at edge k+2.
    logic m_busy = 1'b0, m_done = 1'b0, m_ovr = 1'b0, m_pend = 1'b0, m_infl = 1'b0;
    int   m_ptr = 0, m_addr = 0, m_cnt = 0, m_ack_edge = 0, edge_n = 0;
    int   m_exp_adr = 0;
    logic [DATA_W-1:0] m_exp_dat = '0;

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_ptr = 0; m_infl = 1'b0; m_pend = 1'b0;
            end else if (!m_busy) begin
                if (arm) begin
                    m_busy = 1'b1; m_cnt = 0; m_ptr = 0; m_addr = 0;
                    m_done = 1'b0; m_ovr = 1'b0; m_pend = 1'b0; m_infl = 1'b0;
                end
            end else begin
                bit sel;
                int d;
                sel = 1'b0;
                d = int'(decim);
                if (valid) begin
                    if (d <= 1 || m_cnt == d - 1) begin sel = 1'b1; m_cnt = 0; end
                    else m_cnt++;
                end
                if (m_infl) begin
                    if (sel) m_ovr = 1'b1;
                    if (stop) m_pend = 1'b1;
                    if (edge_n == m_ack_edge) begin
                        m_infl = 1'b0;
                        if (m_ptr < DEPTH) m_ptr++;
                        m_addr = (m_addr == DEPTH - 1) ? 0 : m_addr + 1;
                        if ((!WRAP && m_ptr == DEPTH) || m_pend) begin m_busy = 1'b0; m_done = 1'b1; end
                    end
                end else if (stop) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end else if (sel) begin
                    m_infl = 1'b1; m_ack_edge = edge_n + 2; m_exp_adr = m_addr; m_exp_dat = sample;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus bus-cycle shape.
    int  run_len = 0, run_acks = 0;
    logic prev_cyc = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("overrun", 32'(ovr), 32'(m_ovr));
            chk("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
            chk("cyc", 32'(cyc), 32'(m_infl));
            chk("stb", 32'(stb), 32'(m_infl));
            chk("we", 32'(we), 32'(m_infl));
            if (m_infl) begin
                chk("adr", 32'(adr), 32'(m_exp_adr));
                chk("dat", 32'(dat), 32'(m_exp_dat));
            end
            if (rst) begin
                run_len = 0; run_acks = 0;
            end else if (cyc) begin
                run_len++;
                if (ack) run_acks++;
            end else if (prev_cyc) begin
                chk("cyc_len", 32'(run_len), 32'd2);
                chk("acks_per_cyc", 32'(run_acks), 32'd1);
                run_len = 0; run_acks = 0;
            end
            prev_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic pulse_valid(input logic [DATA_W-1:0] s);
        sample = s; valid = 1'b1; @(negedge clk); valid = 1'b0;
    endtask

    initial begin
        int base;
        int n_samp;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_adr", 32'(adr), 32'd0);
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ptr", 32'(wr_ptr), 32'd0);

        // decim 1, one sample every 4 cycles
        decim = 8'd1;
        pulse_arm();
        chk("arm_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            pulse_valid(16'(i));
            idle(3);
        end
        pulse_stop();
        idle(1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ptr", 32'(wr_ptr), 32'd6);
        for (int i = 0; i < 6; i++) chk("t1_mem", 32'(mem[i]), 32'(i + 1));

        // decim 4: 16 strobes produce 4 writes
        decim = 8'd4;
        pulse_arm();
        for (int i = 1; i <= 16; i++) begin
            pulse_valid(16'(32'h100 + i));
            idle(3);
        end
        chk("t2_ptr", 32'(wr_ptr), 32'd4);
        chk("t2_mem0", 32'(mem[0]), 32'h104);
        chk("t2_mem1", 32'(mem[1]), 32'h108);
        chk("t2_mem2", 32'(mem[2]), 32'h10C);
        chk("t2_mem3", 32'(mem[3]), 32'h110);
        pulse_stop();
        idle(1);

        // back-to-back strobes: every third accepted, arm ignored while busy
        decim = 8'd1;
        pulse_arm();
        for (int i = 0; i < 9; i++) begin
            sample = 16'(32'h200 + i); valid = 1'b1; arm = (i == 4);
            @(negedge clk);
        end
        valid = 1'b0; arm = 1'b0;
        idle(4);
        chk("t3_ovr", 32'(ovr), 32'd1);
        chk("t3_ptr", 32'(wr_ptr), 32'd3);
        chk("t3_mem0", 32'(mem[0]), 32'h200);
        chk("t3_mem1", 32'(mem[1]), 32'h203);
        chk("t3_mem2", 32'(mem[2]), 32'h206);
        pulse_stop();
        idle(1);

        // stop while the write is outstanding
        pulse_arm();
        chk("t4_ovr_clr", 32'(ovr), 32'd0);
        pulse_valid(16'h0ABC);
        pulse_stop();
        chk("t4_pend_busy", 32'(busy), 32'd1);
        chk("t4_pend_done", 32'(done), 32'd0);
        idle(3);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_ptr", 32'(wr_ptr), 32'd1);
        chk("t4_mem0", 32'(mem[0]), 32'h0ABC);

        // reset while cyc is high
        pulse_arm();
        pulse_valid(16'h1234);
        chk("t5_cyc_before", 32'(cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_cyc", 32'(cyc), 32'd0);
        chk("t5_we", 32'(we), 32'd0);
        chk("t5_adr", 32'(adr), 32'd0);
        chk("t5_dat", 32'(dat), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        rst = 1'b0;
        idle(2);

        // full-depth capture, decim 0 treated as 1
        decim = 8'd0;
        n_samp = WRAP ? DEPTH + 2 : DEPTH + 1;
        base = ack_cnt;
        pulse_arm();
        for (int i = 1; i <= n_samp; i++) begin
            pulse_valid(16'h8000 ^ 16'(i));
            idle(3);
        end
        chk("t6_ptr", 32'(wr_ptr), 32'd2048);
        if (WRAP) begin
            chk("t6_acks", 32'(ack_cnt - base), 32'd2050);
            chk("t6_busy", 32'(busy), 32'd1);
            chk("t6_done", 32'(done), 32'd0);
            chk("t6_mem0", 32'(mem[0]), 32'h8801);
            chk("t6_mem1", 32'(mem[1]), 32'h8802);
            chk("t6_mem2", 32'(mem[2]), 32'h8003);
            pulse_valid(16'h5555);
            pulse_stop();
            idle(3);
            chk("t6_stop_done", 32'(done), 32'd1);
            chk("t6_stop_busy", 32'(busy), 32'd0);
            chk("t6_stop_mem2", 32'(mem[2]), 32'h5555);
        end else begin
            chk("t6_acks", 32'(ack_cnt - base), 32'd2048);
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_done", 32'(done), 32'd1);
            chk("t6_mem0", 32'(mem[0]), 32'h8001);
            chk("t6_mem2047", 32'(mem[2047]), 32'h8800);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
